rv_multicycle_core: RTL and testbench

Parametrised multi-cycle RV32I-subset core, successor to the single-cycle addi-only CPU top. It fetches over a request/valid instruction-memory handshake and decodes integer ALU, LUI, BEQ/BNE and JAL. It executes through a 3-state FSM and writes back to an internal register file. It exposes a retire/debug port and halts on illegal instructions, ECALL or EBREAK. It sits between the instruction memory model and the testbench scoreboard.

---
 rtl/rv_multicycle_core.sv | 183 ++++++++++++++++++
 tb/tb_rv_multicycle_core.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_core.sv
// rtl/rv_multicycle_core.sv - multi-cycle RV32I-subset core (FETCH/EXEC/WB, halts on faults)
// Integer ALU, LUI/AUIPC, JAL, BEQ/BNE; retire/debug port; sticky halt on illegal or misaligned target.
module rv_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemValid,
  input  logic [31:0] i_imemData,
  output logic        o_retire,
  output logic [31:0] o_retirePC,
  output logic        o_rdWrEn,
  output logic [4:0]  o_rdAddr,
  output logic [31:0] o_rdData,
  output logic        o_halted
);
  localparam int AW = (NUM_REGS == 16) ? 4 : 5;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_result, r_next_pc;
  logic        r_wr;
  logic [4:0]  r_rd;
  logic [31:0] r_regs [NUM_REGS];
  logic        r_imemReq, r_retire, r_rdWrEn, r_halted;
  logic [31:0] r_retirePC, r_rdData;
  logic [4:0]  r_rdAddr;

  logic [6:0]  w_opcode, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2, w_shamt;
  logic [31:0] w_a, w_b, w_rs2_val, w_imm_i, w_imm_u, w_imm_j, w_imm_b;
  logic [31:0] w_alu, w_sra, w_result, w_next_pc, w_pc4;
  logic        w_legal, w_use_rs1, w_use_rs2, w_use_rd, w_wr, w_regs_bad, w_fault, w_taken;

  assign w_opcode  = r_ir[6:0];
  assign w_rd      = r_ir[11:7];
  assign w_f3      = r_ir[14:12];
  assign w_rs1     = r_ir[19:15];
  assign w_rs2     = r_ir[24:20];
  assign w_f7      = r_ir[31:25];
  assign w_imm_i   = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_u   = {r_ir[31:12], 12'h000};
  assign w_imm_j   = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  assign w_imm_b   = {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_pc4     = r_pc + 32'd4;
  assign w_a       = r_regs[w_rs1[AW-1:0]];
  assign w_rs2_val = r_regs[w_rs2[AW-1:0]];
  assign w_b       = (w_opcode == OPC_OP) ? w_rs2_val : w_imm_i;
  assign w_shamt   = w_b[4:0];
  // Kept as its own signed expression so the arithmetic shift is not lost in an unsigned mux
  assign w_sra     = $signed(w_a) >>> w_shamt;

  always_comb begin
    w_alu = 32'h0;
    case (w_f3)
      3'b000: w_alu = (w_opcode == OPC_OP && w_f7[5]) ? (w_a - w_b) : (w_a + w_b);
      3'b001: w_alu = w_a << w_shamt;
      3'b010: w_alu = {31'h0, $signed(w_a) < $signed(w_b)};
      3'b011: w_alu = {31'h0, w_a < w_b};
      3'b100: w_alu = w_a ^ w_b;
      3'b101: w_alu = w_f7[5] ? w_sra : (w_a >> w_shamt);
      3'b110: w_alu = w_a | w_b;
      default: w_alu = w_a & w_b;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;  w_use_rs1 = 1'b0; w_use_rs2 = 1'b0; w_use_rd = 1'b0;
    w_wr = 1'b0;     w_result = w_alu; w_next_pc = w_pc4; w_taken = 1'b0;
    case (w_opcode)
      OPC_OPIMM: begin
        w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_wr = 1'b1;
        if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'h00);
        else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
        else                     w_legal = 1'b1;
      end
      OPC_OP: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; w_wr = 1'b1;
        w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101));
      end
      OPC_LUI: begin
        w_legal = 1'b1; w_use_rd = 1'b1; w_wr = 1'b1; w_result = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1; w_use_rd = 1'b1; w_wr = 1'b1; w_result = r_pc + w_imm_u;
      end
      OPC_JAL: begin
        w_legal = 1'b1; w_use_rd = 1'b1; w_wr = 1'b1; w_result = w_pc4;
        w_next_pc = r_pc + w_imm_j;
      end
      OPC_BRANCH: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001);
        w_taken = w_f3[0] ? (w_a != w_rs2_val) : (w_a == w_rs2_val);
        if (w_taken) w_next_pc = r_pc + w_imm_b;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_regs_bad = (NUM_REGS == 16) &&
                      ((w_use_rs1 && w_rs1[4]) || (w_use_rs2 && w_rs2[4]) || (w_use_rd && w_rd[4]));
  assign w_fault    = !w_legal || w_regs_bad || (w_next_pc[1:0] != 2'b00);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0;
      r_result   <= 32'h0;
      r_next_pc  <= RESET_PC;
      r_wr       <= 1'b0;
      r_rd       <= 5'h0;
      r_imemReq  <= 1'b0;
      r_retire   <= 1'b0;
      r_retirePC <= 32'h0;
      r_rdWrEn   <= 1'b0;
      r_rdAddr   <= 5'h0;
      r_rdData   <= 32'h0;
      r_halted   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'h0;
    end else begin
      r_retire <= 1'b0;
      r_rdWrEn <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (!r_imemReq) begin
            r_imemReq <= 1'b1;
          end else if (i_imemValid) begin
            r_ir      <= i_imemData;
            r_imemReq <= 1'b0;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_fault) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_result  <= w_result;
            r_next_pc <= w_next_pc;
            r_wr      <= w_wr && (w_rd != 5'd0);
            r_rd      <= w_rd;
            r_state   <= S_WB;
          end
        end
        S_WB: begin
          if (r_wr) r_regs[r_rd[AW-1:0]] <= r_result;
          r_rdWrEn   <= r_wr;
          r_rdAddr   <= r_rd;
          r_rdData   <= r_result;
          r_retire   <= 1'b1;
          r_retirePC <= r_pc;
          r_pc       <= r_next_pc;
          r_imemReq  <= 1'b1;
          r_state    <= S_FETCH;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign o_imemReq  = r_imemReq;
  assign o_imemAddr = r_pc;
  assign o_retire   = r_retire;
  assign o_retirePC = r_retirePC;
  assign o_rdWrEn   = r_rdWrEn;
  assign o_rdAddr   = r_rdAddr;
  assign o_rdData   = r_rdData;
  assign o_halted   = r_halted;
endmodule

// File: tb/tb_rv_multicycle_core.sv
// tb/tb_rv_multicycle_core.sv - directed programs checked against an instruction-level model
// A second instance (NUM_REGS=16) covers the RV32E register-range fault.
module tb_rv_multicycle_core;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, valid, ret, we, halted;
  logic [31:0] addr, data, retpc, rdd;
  logic [4:0]  rda;
  logic        req_e, valid_e, ret_e, we_e, halted_e;
  logic [31:0] addr_e, data_e, retpc_e, rdd_e;
  logic [4:0]  rda_e;

  always #5 clk = ~clk;

  rv_multicycle_core #(.RESET_PC(RST_PC), .NUM_REGS(32)) dut (
    .i_clock(clk), .i_reset(rst), .o_imemReq(req), .o_imemAddr(addr),
    .i_imemValid(valid), .i_imemData(data), .o_retire(ret), .o_retirePC(retpc),
    .o_rdWrEn(we), .o_rdAddr(rda), .o_rdData(rdd), .o_halted(halted));

  rv_multicycle_core #(.RESET_PC(RST_PC), .NUM_REGS(16)) dut_e (
    .i_clock(clk), .i_reset(rst), .o_imemReq(req_e), .o_imemAddr(addr_e),
    .i_imemValid(valid_e), .i_imemData(data_e), .o_retire(ret_e), .o_retirePC(retpc_e),
    .o_rdWrEn(we_e), .o_rdAddr(rda_e), .o_rdData(rdd_e), .o_halted(halted_e));

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, last_ret = -1, wcnt = 0, e_rets = 0, g_wait = 0;
  bit g_check = 0;
  int gaps[$];
  logic [31:0] mem [int unsigned];

  typedef struct { logic [31:0] pc; bit we; logic [4:0] rd; logic [31:0] data; } ret_t;
  ret_t        exp_q[$];
  logic [31:0] halt_pc;
  logic [31:0] m_regs [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2, logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [4:0] rd, logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  // Instruction-set model: runs the loaded program to its halt and queues the expected retirements
  task automatic build_model();
    logic [31:0] pc, ir, a, b, ii, res, npc;
    bit ok, wr;
    pc = RST_PC;
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    for (int step = 0; step < 64; step++) begin
      ir  = mem.exists(pc) ? mem[pc] : 32'h0;
      a   = m_regs[ir[19:15]];
      b   = m_regs[ir[24:20]];
      ii  = {{20{ir[31]}}, ir[31:20]};
      ok  = 1; wr = 0; res = 0; npc = pc + 4;
      case (ir[6:0])
        7'h13: begin
          wr = 1;
          case (ir[14:12])
            3'd0: res = a + ii;
            3'd2: res = ($signed(a) < $signed(ii)) ? 1 : 0;
            3'd3: res = (a < ii) ? 1 : 0;
            3'd4: res = a ^ ii;
            3'd6: res = a | ii;
            3'd7: res = a & ii;
            3'd1: begin ok = (ir[31:25] == 0); res = a << ir[24:20]; end
            default: begin
              if (ir[31:25] == 7'h00) res = a >> ir[24:20];
              else if (ir[31:25] == 7'h20) res = $signed(a) >>> ir[24:20];
              else ok = 0;
            end
          endcase
        end
        7'h33: begin
          wr = 1;
          case ({ir[31:25], ir[14:12]})
            {7'h00, 3'd0}: res = a + b;
            {7'h20, 3'd0}: res = a - b;
            {7'h00, 3'd1}: res = a << b[4:0];
            {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 1 : 0;
            {7'h00, 3'd3}: res = (a < b) ? 1 : 0;
            {7'h00, 3'd4}: res = a ^ b;
            {7'h00, 3'd5}: res = a >> b[4:0];
            {7'h20, 3'd5}: res = $signed(a) >>> b[4:0];
            {7'h00, 3'd6}: res = a | b;
            {7'h00, 3'd7}: res = a & b;
            default: ok = 0;
          endcase
        end
        7'h37: begin wr = 1; res = {ir[31:12], 12'h0}; end
        7'h17: begin wr = 1; res = pc + {ir[31:12], 12'h0}; end
        7'h6F: begin
          wr = 1; res = pc + 4;
          npc = pc + {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
        end
        7'h63: begin
          if (ir[14:12] > 3'd1) ok = 0;
          else if ((ir[14:12] == 3'd0) == (a == b))
            npc = pc + {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
        end
        default: ok = 0;
      endcase
      if (npc[1:0] != 0) ok = 0;
      if (!ok) begin
        halt_pc = pc;
        return;
      end
      wr = wr && (ir[11:7] != 0);
      exp_q.push_back('{pc: pc, we: wr, rd: ir[11:7], data: res});
      if (wr) m_regs[ir[11:7]] = res;
      pc = npc;
    end
    halt_pc = pc;
  endtask

  always @(posedge clk) cyc++;

  // Instruction memory: answers each request after g_wait cycles of the request being up
  always @(negedge clk) begin
    if (req) begin
      valid = (wcnt >= g_wait);
      data  = mem.exists(addr) ? mem[addr] : 32'h0;
      wcnt++;
    end else begin
      valid = 1'b0;
      wcnt  = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) e_rets = 0;
    else if (ret_e) e_rets++;
  end

  // Cycle-by-cycle compare against the expected retirement queue
  always @(negedge clk) begin
    if (g_check) begin
      if (ret) begin
        if (last_ret >= 0) gaps.push_back(cyc - last_ret);
        last_ret = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_retire: got retire at pc %h expected none", retpc);
        end else begin
          ret_t e;
          e = exp_q.pop_front();
          check("retire_pc", retpc, e.pc);
          check("rd_wr_en", {31'h0, we}, {31'h0, e.we});
          if (e.we) begin
            check("rd_addr", {27'h0, rda}, {27'h0, e.rd});
            check("rd_data", rdd, e.data);
          end
        end
      end else begin
        check("rd_wr_en_idle", {31'h0, we}, 32'h0);
      end
      if (req) check("imem_addr", addr, (exp_q.size() != 0) ? exp_q[0].pc : halt_pc);
      if (exp_q.size() != 0) check("halted_early", {31'h0, halted}, 32'h0);
      if (halted) check("req_after_halt", {31'h0, req}, 32'h0);
    end
  end

  task automatic start_run(input int wt);
    g_wait = wt;
    gaps.delete();
    last_ret = -1;
    build_model();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    g_check = 1'b1;
  endtask

  task automatic finish_run(input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (halted && exp_q.size() == 0) break;
    end
    repeat (6) @(negedge clk);
    check({name, "_halted"}, {31'h0, halted}, 32'h1);
    check({name, "_retires_left"}, exp_q.size(), 0);
    g_check = 1'b0;
  endtask

  task automatic check_gap(input string name, input int exp_gap);
    if (gaps.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: got no retire gap expected %0d", name, exp_gap);
    end else begin
      foreach (gaps[i]) check(name, gaps[i], exp_gap);
    end
  endtask

  task automatic load_two_addi();
    mem.delete();
    mem[32'h100] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5);
    mem[32'h104] = enc_i(7'h13, 3'd0, 5'd2, 5'd1, 12'hFF9);
    mem[32'h108] = 32'h0000_0073;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; data = 32'h0;
    valid_e = 1'b1; data_e = 32'h0;

    check("enc_addi", enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5), 32'h0050_0093);
    check("enc_jal", enc_j(5'd1, 21'd16), 32'h0100_00EF);

    // Two ADDIs, zero-wait; reset values pinned by hand
    load_two_addi();
    g_wait = 0;
    build_model();
    check("model_x1", m_regs[1], 32'h5);
    check("model_x2", m_regs[2], 32'hFFFF_FFFE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'h0, req}, 32'h0);
    check("rst_addr", addr, 32'h100);
    check("rst_retire", {31'h0, ret}, 32'h0);
    check("rst_wren", {31'h0, we}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_retpc", retpc, 32'h0);
    check("rst_rdaddr", {27'h0, rda}, 32'h0);
    check("rst_rddata", rdd, 32'h0);
    start_run(0);
    @(negedge clk);
    check("release_req", {31'h0, req}, 32'h1);
    check("release_addr", addr, 32'h100);
    finish_run("addi0");
    check_gap("gap_zero_wait", 3);

    // Same program with two wait cycles per fetch
    load_two_addi();
    start_run(2);
    finish_run("addi2");
    check_gap("gap_two_wait", 5);

    // BNE taken, BEQ not taken
    mem.delete();
    mem[32'h100] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5);
    mem[32'h104] = enc_b(3'd1, 5'd1, 5'd0, 13'd8);
    mem[32'h108] = enc_i(7'h13, 3'd0, 5'd5, 5'd0, 12'd99);
    mem[32'h10C] = enc_b(3'd0, 5'd1, 5'd0, 13'd8);
    mem[32'h110] = 32'h0000_0073;
    start_run(0);
    check("model_bne_target", exp_q[2].pc, 32'h10C);
    check("model_branch_halt", halt_pc, 32'h110);
    finish_run("branch");

    // JAL, x0 write, and an ALU mix
    mem.delete();
    mem[32'h100] = enc_j(5'd1, 21'd16);
    mem[32'h110] = enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd1);
    mem[32'h114] = enc_i(7'h13, 3'd0, 5'd4, 5'd0, 12'd7);
    mem[32'h118] = enc_u(7'h37, 5'd6, 20'h12345);
    mem[32'h11C] = enc_u(7'h17, 5'd7, 20'h00001);
    mem[32'h120] = enc_r(7'h20, 5'd4, 5'd0, 3'd0, 5'd8);
    mem[32'h124] = enc_i(7'h13, 3'd5, 5'd9, 5'd8, 12'h401);
    mem[32'h128] = enc_i(7'h13, 3'd5, 5'd10, 5'd8, 12'h01C);
    mem[32'h12C] = enc_r(7'h00, 5'd4, 5'd8, 3'd2, 5'd11);
    mem[32'h130] = enc_r(7'h00, 5'd4, 5'd8, 3'd3, 5'd12);
    mem[32'h134] = enc_r(7'h00, 5'd4, 5'd4, 3'd1, 5'd13);
    mem[32'h138] = enc_i(7'h13, 3'd4, 5'd14, 5'd8, 12'hFFF);
    mem[32'h13C] = 32'h0010_0073;
    start_run(1);
    check("model_jal_link", m_regs[1], 32'h104);
    check("model_jal_target", exp_q[1].pc, 32'h110);
    check("model_x0_nowrite", {31'h0, exp_q[1].we}, 32'h0);
    check("model_x4", m_regs[4], 32'h7);
    check("model_auipc", m_regs[7], 32'h111C);
    check("model_srai", m_regs[9], 32'hFFFF_FFFC);
    check("model_srli", m_regs[10], 32'hF);
    check("model_sll", m_regs[13], 32'h380);
    check("model_xori", m_regs[14], 32'h6);
    finish_run("jal_alu");

    // Misaligned taken branch halts without retiring it
    mem.delete();
    mem[32'h100] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd1);
    mem[32'h104] = enc_b(3'd1, 5'd1, 5'd0, 13'd6);
    start_run(0);
    check("model_misalign_halt", halt_pc, 32'h104);
    finish_run("misalign");

    // SLLI with funct7=0100000 is illegal at the first instruction
    mem.delete();
    mem[32'h100] = enc_i(7'h13, 3'd1, 5'd1, 5'd0, 12'h401);
    start_run(0);
    check("model_slli_bad", exp_q.size(), 0);
    finish_run("slli_bad");

    // RV32E instance: x17 faults, x15 retires
    data_e = enc_i(7'h13, 3'd0, 5'd17, 5'd0, 12'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("e_x17_halted", {31'h0, halted_e}, 32'h1);
    check("e_x17_retires", e_rets, 0);
    check("e_x17_req", {31'h0, req_e}, 32'h0);
    data_e = enc_i(7'h13, 3'd0, 5'd15, 5'd0, 12'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("e_reset_clears_halt", {31'h0, halted_e}, 32'h0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("e_x15_halted", {31'h0, halted_e}, 32'h0);
    check("e_x15_retired", {31'h0, e_rets > 2}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
